// File: rtl/sparce_sasa_loader_pkg.sv
// Shared types for the SparCE SASA table loader: machine word type, loader states,
// table base address and the word-address helper used by both address generators.
package rv32i_types_pkg;

  typedef logic [31:0] word_t;

endpackage

package sparce_pkg;

  import rv32i_types_pkg::*;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } sasa_load_state_t;

  localparam logic [31:0] SASA_TABLE_BASE = 32'h0000_0000;

  // Byte address of word idx above base; wraps mod 2^32 by construction.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/sparce_sasa_loader.sv
// SparCE SASA table loader: fetches a descriptor image word by word from memory and
// replays each word as a table write, gating table lookups until a full load completes.
//
// Handshake: mem_ren/mem_addr form a request that is held stable for as long as
// mem_busy is high; a word is accepted (mem_rdata captured) in the READ cycle where
// mem_busy is low. sasa_wen is a single-cycle strobe with no back-pressure.
module sparce_sasa_loader
  import sparce_pkg::*, rv32i_types_pkg::*;
#(
  parameter int          MAX_WORDS  = 64,
  parameter logic [31:0] TABLE_BASE = SASA_TABLE_BASE,
  localparam int         CW         = $clog2(MAX_WORDS) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      base_addr,
  input  logic [CW-1:0]    num_words,
  input  logic             enable_req,
  output logic             mem_ren,
  output logic [31:0]      mem_addr,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_busy,
  output logic [31:0]      sasa_addr,
  output word_t            sasa_data,
  output logic             sasa_wen,
  output logic             sasa_enable,
  output logic             busy,
  output logic             done,
  output logic             error,
  output sasa_load_state_t dbg_state
);

  sasa_load_state_t r_state;
  sasa_load_state_t w_next_state;

  logic [31:0]   r_base;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_idx;
  word_t         r_data;
  logic          r_loaded;
  logic          r_error;

  logic          w_illegal;
  logic          w_last;

  assign w_illegal = (base_addr[1:0] != 2'b00) ||
                     ({{(32-CW){1'b0}}, num_words} > 32'(MAX_WORDS));
  assign w_last    = (r_idx == (r_count - CW'(1)));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= IDLE;
      r_base   <= '0;
      r_count  <= '0;
      r_idx    <= '0;
      r_data   <= '0;
      r_loaded <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_illegal) begin
              r_error <= 1'b1;
            end else begin
              r_error  <= 1'b0;
              r_loaded <= 1'b0;
              r_base   <= base_addr;
              r_count  <= num_words;
              r_idx    <= '0;
            end
          end
        end
        READ: begin
          if (abort) begin
            r_loaded <= 1'b0;
          end else if (!mem_busy) begin
            r_data <= mem_rdata;
          end
        end
        WRITE: begin
          if (abort) begin
            r_loaded <= 1'b0;
          end else if (!w_last) begin
            r_idx <= r_idx + CW'(1);
          end
        end
        DONE: begin
          // An abort landing on the done cycle still invalidates the table.
          r_loaded <= !abort;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (start && !w_illegal) begin
          w_next_state = (num_words == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (abort) begin
          w_next_state = IDLE;
        end else if (!mem_busy) begin
          w_next_state = WRITE;
        end
      end
      WRITE: begin
        if (abort) begin
          w_next_state = IDLE;
        end else if (w_last) begin
          w_next_state = DONE;
        end else begin
          w_next_state = READ;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_ren   = 1'b0;
    mem_addr  = '0;
    sasa_wen  = 1'b0;
    sasa_addr = '0;
    sasa_data = '0;
    if (r_state == READ) begin
      mem_ren  = 1'b1;
      mem_addr = word_addr(r_base, 32'(r_idx));
    end
    if (r_state == WRITE) begin
      sasa_wen  = 1'b1;
      sasa_addr = word_addr(TABLE_BASE, 32'(r_idx));
      sasa_data = r_data;
    end
  end

  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);
  assign error       = r_error;
  assign sasa_enable = enable_req & r_loaded & (r_state == IDLE);
  assign dbg_state   = r_state;

endmodule
